nmi_arbiter: RTL and testbench
==============================

# nmi_arbiter

Two-master arbiter that shares the single native memory interface (NMI) bus in front of the address decoder between the CPU core and a second bus master, such as a DMA engine or debug module. It performs round-robin arbitration and locks the grant for a whole transaction. Only the granted master's request is forwarded downstream, and ready/rdata are routed back only to that master. An optional watchdog terminates transactions that the downstream slave never acknowledges.

## Interface
Parameters:
- TIMEOUT_CYC, default 1023: cycles in BUSY before watchdog abort. The range is 1..65535. Used only when the watchdog is compiled in.
- TIMEOUT_RDATA, default 32'hDEAD_BEEF: rdata returned to the master on a watchdog abort.

Ports:
- clk_i  input  1  system clock; single clock domain.
- rst_n_i  input  1  asynchronous, active-low reset.
- m0_nmi  nmi_if.slave  —  master 0 (CPU core): valid, addr[31:0], wdata[31:0], wstrb[3:0] in; rdata[31:0], ready out.
- m1_nmi  nmi_if.slave  —  master 1 (DMA/debug): same signal set as m0_nmi.
- s_nmi  nmi_if.master  —  downstream port to the bus decoder.
- arb_gnt_o  output  2  one-hot current grant; 2'b00 when IDLE.
- timeout_o  output  1  one-cycle pulse on watchdog abort.

## Operation
- FSM has two states: IDLE and BUSY.
- Registered state: state, gnt (0/1), last_gnt.
  - Reset values: state=IDLE, last_gnt=1 (so m0 wins the first tie), watchdog counter=0.
- IDLE:
  - If only one master asserts valid, register gnt = that master and move to BUSY.
  - If both assert valid, gnt = the master other than last_gnt.
  - If neither asserts valid, stay in IDLE.
- BUSY:
  - s_nmi.valid/addr/wdata/wstrb mirror the granted master combinationally.
  - granted.ready = s_nmi.ready and granted.rdata = s_nmi.rdata.
  - The ungranted master sees ready=0 and rdata=0.
- Completion: when s_nmi.valid && s_nmi.ready in BUSY, set last_gnt=gnt and go to IDLE.
- Protocol violation: if the granted master drops valid in BUSY, s_nmi.valid drops the same cycle. The FSM returns to IDLE with no ready issued and last_gnt updated.
- IDLE outputs: s_nmi.valid=0; s_nmi.addr/wdata=0 and s_nmi.wstrb=0 (so no stray SRAM writes); both masters ready=0, rdata=0.
- Masters must hold valid and payload stable until ready, per NMI rules. The arbiter does not register the payload.
- Reset mid-transaction: all outputs go to their IDLE values immediately. The in-flight transaction is lost and no ready is generated.

## Timing
- Arbitration latency is 1 cycle: a valid seen in IDLE at edge N produces s_nmi.valid in cycle N+1.
- Ready/rdata have zero added latency: they are combinational from s_nmi to the granted master.
- Minimum spacing between accepted transactions is 2 cycles, because IDLE always lasts at least 1 cycle between grants.
- Fairness: with both masters requesting continuously, grants alternate m0, m1, m0, …
- No combinational path runs from any master valid to s_nmi.valid in IDLE.

## Configuration
- Macro: NMI_ARB_WDT_EN.
- Defined:
  - A 16-bit counter clears on entering BUSY and increments every BUSY cycle without ready.
  - When count == TIMEOUT_CYC-1 and s_nmi.ready=0:
    - s_nmi.valid drops the following cycle.
    - The granted master receives ready=1 with rdata=TIMEOUT_RDATA for exactly one cycle.
    - timeout_o pulses, and the FSM moves to IDLE with last_gnt updated.
  - If the slave's ready arrives in the same cycle as the terminal count, normal completion wins and there is no pulse.
- Undefined: no counter exists, timeout_o is tied to 0, and a hung slave stalls the bus indefinitely.

## Structure
- Shared package nmi_arb_pkg holds:
  - the state enum (NMI_ARB_IDLE, NMI_ARB_BUSY);
  - the default TIMEOUT_RDATA constant.
- Sub-module nmi_arb_wdt contains the watchdog counter and terminal-count compare. It is instantiated only under NMI_ARB_WDT_EN.
- Flops use the existing dffr-style reset register cells.

## Test plan
- Reset release with no requests: arb_gnt_o=00, s_nmi.valid=0, both ready=0 for 10 cycles.
- m0 reads 0x0000_0100; the slave returns ready after 3 cycles with rdata 0x1234_5678. Required: s_nmi.valid one cycle after m0 valid, m0 ready with 0x1234_5678, m1 ready stays 0.
- m0 and m1 request in the same cycle, both continuously, for 6 transactions with single-cycle ready. Required: grant order m0, m1, m0, m1, m0, m1, and each start is 2 cycles apart.
- m1 writes wstrb=4'hF while m0 is idle, then m0 requests mid-transaction. Required: m1 completes first, then m0 is granted; m0 ready stays 0 throughout m1's transaction.
- With NMI_ARB_WDT_EN and TIMEOUT_CYC=8, m1 targets a slave that never readies. Required: after 8 BUSY cycles, m1 gets ready=1 with rdata=0xDEAD_BEEF, timeout_o pulses once, and the FSM returns to IDLE.
- rst_n_i is asserted in the second BUSY cycle of an m0 read. Required: s_nmi.valid=0 and arb_gnt_o=00 immediately; after release, m0 wins a tie against m1.

Source files
------------

// File: rtl/nmi_arb_pkg.sv
// -----------------------------------------------------------------------------
// nmi_arb_pkg
// Shared definitions for the two-master NMI arbiter:
//   - nmi_arb_state_e        : arbiter FSM state encoding (IDLE / BUSY)
//   - NMI_ARB_TIMEOUT_RDATA  : default read data returned on a watchdog abort
// -----------------------------------------------------------------------------
package nmi_arb_pkg;

  typedef enum logic {
    NMI_ARB_IDLE = 1'b0,
    NMI_ARB_BUSY = 1'b1
  } nmi_arb_state_e;

  localparam logic [31:0] NMI_ARB_TIMEOUT_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/nmi_if.sv
// -----------------------------------------------------------------------------
// nmi_if
// Native memory interface bundle.
//   valid, addr[31:0], wdata[31:0], wstrb[3:0] : request, master -> slave
//   rdata[31:0], ready                         : response, slave -> master
// Modports:
//   master : drives the request, receives the response
//   slave  : receives the request, drives the response
// -----------------------------------------------------------------------------
interface nmi_if;

  logic        valid;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [31:0] rdata;
  logic        ready;

  modport master (
    output valid, addr, wdata, wstrb,
    input  rdata, ready
  );

  modport slave (
    input  valid, addr, wdata, wstrb,
    output rdata, ready
  );

endinterface

// File: rtl/nmi_arb_wdt.sv
// -----------------------------------------------------------------------------
// nmi_arb_wdt
// Watchdog for the NMI arbiter. Only instantiated when NMI_ARB_WDT_EN is
// defined.
// Ports:
//   clk_i    in  system clock
//   rst_n_i  in  asynchronous active-low reset
//   en_i     in  arbiter is forwarding a transaction (BUSY, not aborting)
//   ready_i  in  downstream ready
//   tc_o     out terminal count reached this cycle without ready
// The counter is held at zero outside BUSY, so it is clear on entering BUSY.
// -----------------------------------------------------------------------------
module nmi_arb_wdt #(
  parameter int unsigned TIMEOUT_CYC = 1023
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic en_i,
  input  logic ready_i,
  output logic tc_o
);

  localparam logic [15:0] LAST_CNT = 16'(TIMEOUT_CYC - 1);

  logic [15:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else if (!en_i) begin
      cnt_q <= '0;
    end else if (!ready_i) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  // A ready arriving on the terminal cycle suppresses the abort.
  assign tc_o = en_i && !ready_i && (cnt_q == LAST_CNT);

endmodule

// File: rtl/nmi_arbiter.sv
// -----------------------------------------------------------------------------
// nmi_arbiter
// Round-robin arbiter sharing one downstream NMI port between two masters.
// The grant is locked for a whole transaction; only the granted master's
// request is forwarded, and ready/rdata are returned only to that master.
// Optional watchdog (macro NMI_ARB_WDT_EN) aborts transactions the slave never
// acknowledges, answering the master with TIMEOUT_RDATA.
// Ports:
//   clk_i      in   system clock
//   rst_n_i    in   asynchronous active-low reset
//   m0_nmi     slave modport, master 0 (CPU core)
//   m1_nmi     slave modport, master 1 (DMA / debug)
//   s_nmi      master modport, downstream to the bus decoder
//   arb_gnt_o  out  one-hot grant, 2'b00 when idle
//   timeout_o  out  one-cycle pulse on watchdog abort (0 without watchdog)
// -----------------------------------------------------------------------------
module nmi_arbiter
  import nmi_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC   = 1023,
  parameter logic [31:0] TIMEOUT_RDATA = NMI_ARB_TIMEOUT_RDATA
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  nmi_if.slave       m0_nmi,
  nmi_if.slave       m1_nmi,
  nmi_if.master      s_nmi,
  output logic [1:0] arb_gnt_o,
  output logic       timeout_o
);

  nmi_arb_state_e state_q;
  logic           gnt_q;       // 0 = m0, 1 = m1
  logic           last_gnt_q;
  logic [1:0]     arb_gnt_q;
  logic           abort_q;     // watchdog abort response cycle

  logic        busy;
  logic        fwd;
  logic        sel_valid;
  logic        s_valid;
  logic        win;
  logic        done;
  logic        grant_ready;
  logic [31:0] grant_rdata;
  logic        wdt_tc;

  assign busy      = (state_q == NMI_ARB_BUSY);
  assign sel_valid = gnt_q ? m1_nmi.valid : m0_nmi.valid;
  // During the abort cycle the request is withdrawn from the slave.
  assign fwd       = busy && !abort_q;
  assign s_valid   = fwd && sel_valid;

  // Tie goes to the master that was not served last.
  assign win = (m0_nmi.valid && m1_nmi.valid) ? ~last_gnt_q : m1_nmi.valid;

  // Transaction ends on handshake, abort, or the master dropping valid.
  assign done = busy && (abort_q || !sel_valid || s_nmi.ready);

`ifdef NMI_ARB_WDT_EN
  nmi_arb_wdt #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_wdt (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .en_i    (s_valid),
    .ready_i (s_nmi.ready),
    .tc_o    (wdt_tc)
  );
`else
  logic [15:0] unused_timeout_cyc;
  assign unused_timeout_cyc = 16'(TIMEOUT_CYC);
  assign wdt_tc  = 1'b0;
  assign abort_q = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= NMI_ARB_IDLE;
      gnt_q      <= 1'b0;
      last_gnt_q <= 1'b1;
      arb_gnt_q  <= 2'b00;
`ifdef NMI_ARB_WDT_EN
      abort_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        NMI_ARB_IDLE: begin
          if (m0_nmi.valid || m1_nmi.valid) begin
            state_q   <= NMI_ARB_BUSY;
            gnt_q     <= win;
            arb_gnt_q <= win ? 2'b10 : 2'b01;
          end
        end
        NMI_ARB_BUSY: begin
          if (done) begin
            state_q    <= NMI_ARB_IDLE;
            last_gnt_q <= gnt_q;
            arb_gnt_q  <= 2'b00;
          end
`ifdef NMI_ARB_WDT_EN
          abort_q <= !done && wdt_tc;
`endif
        end
        default: begin
          state_q   <= NMI_ARB_IDLE;
          arb_gnt_q <= 2'b00;
        end
      endcase
    end
  end

  // Downstream request: zero payload whenever nothing is forwarded.
  assign s_nmi.valid = s_valid;
  assign s_nmi.addr  = fwd ? (gnt_q ? m1_nmi.addr  : m0_nmi.addr)  : 32'h0;
  assign s_nmi.wdata = fwd ? (gnt_q ? m1_nmi.wdata : m0_nmi.wdata) : 32'h0;
  assign s_nmi.wstrb = fwd ? (gnt_q ? m1_nmi.wstrb : m0_nmi.wstrb) : 4'h0;

  // Response to the granted master only; ready needs a live request.
  assign grant_ready = abort_q || (s_valid && s_nmi.ready);
  assign grant_rdata = abort_q ? TIMEOUT_RDATA : s_nmi.rdata;

  assign m0_nmi.ready = busy && !gnt_q && grant_ready;
  assign m0_nmi.rdata = (busy && !gnt_q) ? grant_rdata : 32'h0;
  assign m1_nmi.ready = busy && gnt_q && grant_ready;
  assign m1_nmi.rdata = (busy && gnt_q) ? grant_rdata : 32'h0;

  assign arb_gnt_o = arb_gnt_q;
  assign timeout_o = abort_q;

endmodule

// File: tb/tb_nmi_arbiter.sv
// -----------------------------------------------------------------------------
// tb_nmi_arbiter
// Directed bench for nmi_arbiter. Expected completions are queued by the
// stimulus; a negedge monitor pops and compares on every master ready.
// Watchdog scenario is compiled only when NMI_ARB_WDT_EN is defined.
// -----------------------------------------------------------------------------
module tb_nmi_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  nmi_if m0_if();
  nmi_if m1_if();
  nmi_if s_if();

  logic [1:0] arb_gnt;
  logic       timeout;

  nmi_arbiter #(
    .TIMEOUT_CYC   (8),
    .TIMEOUT_RDATA (32'hDEAD_BEEF)
  ) dut (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .m0_nmi    (m0_if.slave),
    .m1_nmi    (m1_if.slave),
    .s_nmi     (s_if.master),
    .arb_gnt_o (arb_gnt),
    .timeout_o (timeout)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    bit          id;
    logic [31:0] rdata;
  } exp_t;
  exp_t exp_q[$];

  int cyc = 0;
  int starts[$];
  int timeout_pulses = 0;
  logic s_valid_prev = 1'b0;

  // slave model controls / write capture
  int          slave_lat  = 0;
  bit          slave_hang = 1'b0;
  int          scnt       = 0;
  logic [31:0] wr_addr    = 32'h0;
  logic [31:0] wr_data    = 32'h0;
  logic [3:0]  wr_strb    = 4'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input bit id, input logic [31:0] rd);
    exp_t e;
    e.id    = id;
    e.rdata = rd;
    exp_q.push_back(e);
  endtask

  task automatic drive(input bit id, input logic v, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] ws);
    if (id) begin
      m1_if.valid = v; m1_if.addr = a; m1_if.wdata = wd; m1_if.wstrb = ws;
    end else begin
      m0_if.valid = v; m0_if.addr = a; m0_if.wdata = wd; m0_if.wstrb = ws;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the handshake edge.
  task automatic m_issue(input bit id, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] ws);
    bit got;
    got = 1'b0;
    drive(id, 1'b1, a, wd, ws);
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      if (id ? m1_if.ready : m0_if.ready) got = 1'b1;
    end
    check(id ? "m1_ready_seen" : "m0_ready_seen", {31'b0, got}, 32'd1);
    @(posedge clk); #1;
    drive(id, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  always @(posedge clk) cyc++;

  // slave: updates at posedge+2, after the masters have settled
  initial begin
    s_if.ready = 1'b0;
    s_if.rdata = 32'h0;
    forever begin
      @(posedge clk); #2;
      if (s_if.valid) begin
        s_if.rdata = (s_if.addr == 32'h100) ? 32'h1234_5678 : ~s_if.addr;
        if (!slave_hang && scnt >= slave_lat) begin
          s_if.ready = 1'b1;
          if (s_if.wstrb != 4'h0) begin
            wr_addr = s_if.addr; wr_data = s_if.wdata; wr_strb = s_if.wstrb;
          end
        end else begin
          s_if.ready = 1'b0;
        end
        scnt++;
      end else begin
        s_if.ready = 1'b0;
        s_if.rdata = 32'h0;
        scnt = 0;
      end
    end
  end

  // monitor / scoreboard
  always @(negedge clk) begin
    bit          id;
    logic [31:0] rd;
    exp_t        e;
    if (m0_if.ready || m1_if.ready) begin
      id = m1_if.ready;
      rd = id ? m1_if.rdata : m0_if.rdata;
      $display("[TB] txn done: m%0d rdata=%h gnt=%b timeout=%b", id, rd, arb_gnt, timeout);
      check("both_ready", {31'b0, m0_if.ready && m1_if.ready}, 32'd0);
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL unexpected_txn: m%0d ready with rdata %h, expected no transaction", id, rd);
      end else begin
        e = exp_q.pop_front();
        check("txn_master", {31'b0, id}, {31'b0, e.id});
        check("txn_rdata", rd, e.rdata);
        check("ungranted_rdata", id ? m0_if.rdata : m1_if.rdata, 32'h0);
        check("txn_gnt", {30'b0, arb_gnt}, id ? 32'd2 : 32'd1);
      end
    end
    if (timeout) timeout_pulses++;
    if (s_if.valid && !s_valid_prev) starts.push_back(cyc);
    s_valid_prev = s_if.valid;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "global timeout");
  end

  initial begin
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // idle after reset
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_outputs", {27'b0, arb_gnt, s_if.valid, m0_if.ready, m1_if.ready}, 32'd0);
    end

    // both masters continuously, single-cycle ready: m0,m1,m0,m1,m0,m1
    slave_lat = 0;
    starts.delete();
    push_exp(1'b0, 32'hFFFF_FDFF);
    push_exp(1'b1, 32'hFFFF_FCFF);
    push_exp(1'b0, 32'hFFFF_FDFB);
    push_exp(1'b1, 32'hFFFF_FCFB);
    push_exp(1'b0, 32'hFFFF_FDF7);
    push_exp(1'b1, 32'hFFFF_FCF7);
    @(posedge clk); #1;
    fork
      begin
        m_issue(1'b0, 32'h200, 32'h0, 4'h0);
        m_issue(1'b0, 32'h204, 32'h0, 4'h0);
        m_issue(1'b0, 32'h208, 32'h0, 4'h0);
      end
      begin
        m_issue(1'b1, 32'h300, 32'h0, 4'h0);
        m_issue(1'b1, 32'h304, 32'h0, 4'h0);
        m_issue(1'b1, 32'h308, 32'h0, 4'h0);
      end
    join
    check("rr_start_count", starts.size(), 32'd6);
    for (int i = 1; i < starts.size(); i++)
      check("rr_start_spacing", starts[i] - starts[i-1], 32'd2);
    check("rr_queue_empty", exp_q.size(), 32'd0);

    // m0 read, slave ready after 3 cycles
    slave_lat = 3;
    push_exp(1'b0, 32'h1234_5678);
    @(posedge clk); #1;
    fork
      m_issue(1'b0, 32'h100, 32'h0, 4'h0);
      begin
        @(negedge clk);
        check("rd_no_comb_path", {31'b0, s_if.valid}, 32'd0);
        @(negedge clk);
        check("rd_s_valid", {31'b0, s_if.valid}, 32'd1);
        check("rd_gnt", {30'b0, arb_gnt}, 32'd1);
        check("rd_s_addr", s_if.addr, 32'h100);
      end
    join
    check("rd_queue_empty", exp_q.size(), 32'd0);

    // m1 write, m0 requests mid-transaction
    slave_lat = 3;
    push_exp(1'b1, 32'hFFFF_FBFF);
    push_exp(1'b0, 32'hFFFF_FEFB);
    @(posedge clk); #1;
    fork
      m_issue(1'b1, 32'h400, 32'hCAFE_F00D, 4'hF);
      begin
        repeat (2) @(posedge clk);
        #1;
        m_issue(1'b0, 32'h104, 32'h0, 4'h0);
      end
      begin
        int bad;
        bad = 0;
        repeat (6) begin
          @(negedge clk);
          if (arb_gnt == 2'b10 && m0_if.ready) bad++;
        end
        check("wr_m0_ready_during_m1", bad, 32'd0);
      end
    join
    check("wr_addr", wr_addr, 32'h400);
    check("wr_data", wr_data, 32'hCAFE_F00D);
    check("wr_strb", {28'b0, wr_strb}, 32'hF);
    check("wr_queue_empty", exp_q.size(), 32'd0);

    // reset in second BUSY cycle of an m0 read
    slave_hang = 1'b1;
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 32'h108, 32'h0, 4'h0);
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("rst_s_valid", {31'b0, s_if.valid}, 32'd0);
    check("rst_gnt", {30'b0, arb_gnt}, 32'd0);
    check("rst_m0_ready", {31'b0, m0_if.ready}, 32'd0);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    slave_hang = 1'b0;
    slave_lat = 0;
    @(negedge clk);
    rst_n = 1'b1;
    push_exp(1'b0, 32'hFFFF_FEF3);
    push_exp(1'b1, 32'hFFFF_FCF3);
    @(posedge clk); #1;
    fork
      m_issue(1'b0, 32'h10C, 32'h0, 4'h0);
      m_issue(1'b1, 32'h30C, 32'h0, 4'h0);
      begin
        @(negedge clk);
        @(negedge clk);
        check("rst_tie_gnt", {30'b0, arb_gnt}, 32'd1);
      end
    join
    check("rst_queue_empty", exp_q.size(), 32'd0);

`ifdef NMI_ARB_WDT_EN
    // m1 targets a slave that never readies
    slave_hang = 1'b1;
    push_exp(1'b1, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    fork
      m_issue(1'b1, 32'h500, 32'h0, 4'h0);
      begin
        int vcyc;
        bit seen;
        vcyc = 0;
        seen = 1'b0;
        for (int n = 0; n < 30 && !seen; n++) begin
          @(negedge clk);
          if (m1_if.ready) begin
            seen = 1'b1;
            check("wdt_timeout_pulse", {31'b0, timeout}, 32'd1);
            check("wdt_s_valid_dropped", {31'b0, s_if.valid}, 32'd0);
          end else if (s_if.valid) begin
            vcyc++;
          end
        end
        check("wdt_busy_cycles", vcyc, 32'd8);
      end
    join
    @(negedge clk);
    check("wdt_idle_gnt", {30'b0, arb_gnt}, 32'd0);
    check("wdt_pulse_cleared", {31'b0, timeout}, 32'd0);
    slave_hang = 1'b0;
    check("timeout_pulse_total", timeout_pulses, 32'd1);
`else
    check("timeout_pulse_total", timeout_pulses, 32'd0);
`endif
    check("final_queue_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
